alu_code_unit: RTL and testbench
================================

# alu_code_unit

Registered 4-bit ALU with a 2-digit multiplexed hex seven-segment display driver. It is a leaf block for board-level demos: operands and opcode come from switches, and the output drives a common 2-digit LED display. Each cycle it computes an 8-bit result from `a`, `b` and `f`, registers it together with a 4-bit flag bank, and time-multiplexes the two hex digits of the result onto `du`.

## Interface
Parameters:
- `REFRESH_BITS`, default 16: width of the display refresh counter. The digit select toggles every 2^REFRESH_BITS clocks. Minimum 1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input 4: operand A, unsigned.
- `b` input 4: operand B, unsigned.
- `f` input 4: opcode.
- `du` output 7: segment drive for the active digit, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- `d0` output 1: enable for the low digit (result[3:0]), active-high.
- `d1` output 1: enable for the high digit (result[7:4]), active-high.
- `bank` output 4: registered flags {C, Z, N, V} (bit3..bit0).

## Operation
Opcodes by `f`; `result` is 8 bits. All ops zero-extend unless stated.
- 0: ADD, a+b. C=result[4]. V = 4-bit signed overflow.
- 1: SUB, a−b, two's-complement sign-extended to 8 bits. C = borrow (a<b). V = 4-bit signed overflow.
- 2: MUL, a×b, 8-bit; only with `ALU_MUL_EN` (see Configuration).
- 3: AND.
- 4: OR.
- 5: XOR.
- 6: NAND (4-bit, upper nibble 0).
- 7: NOR (4-bit, upper nibble 0).
- 8: XNOR (4-bit, upper nibble 0).
- 9: NOT a (4-bit, upper nibble 0).
- 10: a << b[1:0], 8-bit result. C=0.
- 11: a >> b[1:0]. C = last bit shifted out; 0 when shift is 0.
- 12: 4-bit rotate-left of a by b[1:0].
- 13: 4-bit rotate-right of a by b[1:0].
- 14: a+1, 8-bit. C=result[4].
- 15: compare. result = 8'h01 if a>b, 8'h00 if a==b, 8'hFF if a<b.

Flag rules:
- Z = (result==0).
- N = result[7].
- C and V are 0 for every op not listed above as setting them.

Display:
- Each digit is hex-decoded (0–F) with standard seven-segment glyphs.
- Exactly one of d0/d1 is high at all times.
- `du` always shows the glyph of the nibble whose enable is high.

## Timing
- Reset: result=0, bank=0, refresh counter=0, digit select=low digit. Outputs during reset are d0=1, d1=0, du=7'b1111110 (glyph "0").
- Latency: inputs sampled on rising edge N; result and bank are valid after edge N. Operand or opcode changes take effect one cycle later.
- `du`, `d0` and `d1` are registered outputs, updated on the same edge as the result.
- The refresh counter is free-running and wraps modulo 2^REFRESH_BITS. On wrap, the digit select toggles.
- Reset deasserted mid-refresh: the counter restarts from 0.
- An opcode change does not reset the refresh counter.

## Configuration
- `ALU_MUL_EN` defined: f=2 computes the 8-bit product a×b, with C=V=0.
- `ALU_MUL_EN` undefined: no multiplier is built. f=2 yields result=0 and bank=4'b0100 (Z=1).

## Test plan
- Reset: hold rst_n=0 -> bank=0, d0=1, d1=0, du=7'b1111110. With REFRESH_BITS=1, release rst_n -> d0/d1 alternate every 2 clocks.
- a=1, b=1, f=0 -> one cycle later result=8'h02, bank=4'b0000; low digit glyph "2", high digit "0".
- a=2, b=1, f=1 -> result=8'h01, bank=0. Then a=1, b=2, f=1 -> result=8'hFF, bank=4'b1010 (C=1, N=1).
- a=15, b=0, f=5 -> result=8'h0F, bank=0; low digit glyph "F".
- a=7, b=1, f=0 -> result=8'h08, V=1, bank=4'b0001. Then a=0, b=0, f=3 -> bank=4'b0100.
- a=15, b=15, f=2 -> result=8'hE1 with ALU_MUL_EN; result=0 and Z=1 without it.

Source files
------------

// File: rtl/alu_code_unit.sv
// -----------------------------------------------------------------------------
// alu_code_unit
//   Registered 4-bit ALU driving a 2-digit multiplexed hex seven-segment
//   display. Every clock the 8-bit result of (a, f, b) and the {C,Z,N,V} flag
//   bank are registered; the two result nibbles are time-multiplexed onto du.
//
// Parameters
//   REFRESH_BITS : width of the free-running refresh counter (>= 1); the
//                  digit select toggles every 2^REFRESH_BITS clocks.
//
// Ports
//   clk   in  1 : clock, rising edge
//   rst_n in  1 : asynchronous active-low reset
//   a     in  4 : operand A (unsigned)
//   b     in  4 : operand B (unsigned)
//   f     in  4 : opcode
//   du    out 7 : active-high segments {a,b,c,d,e,f,g} of the enabled digit
//   d0    out 1 : low digit (result[3:0]) enable
//   d1    out 1 : high digit (result[7:4]) enable
//   bank  out 4 : registered flags {C,Z,N,V}
//
// Build option
//   ALU_MUL_EN : when defined, f=2 is the 8-bit product a*b; otherwise no
//                multiplier is built and f=2 yields zero (Z=1).
// -----------------------------------------------------------------------------
module alu_code_unit #(
   parameter int unsigned REFRESH_BITS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] f,
   output logic [6:0] du,
   output logic       d0,
   output logic       d1,
   output logic [3:0] bank
);

   typedef enum logic {DIG_LO = 1'b0, DIG_HI = 1'b1} digit_t;

   digit_t                  sel;
   digit_t                  nxt_sel;
   logic [REFRESH_BITS-1:0] cnt;
   logic [7:0]              result;
   logic [7:0]              nxt_result;
   logic [3:0]              nxt_bank;
   logic [6:0]              nxt_du;

   logic [4:0] sum5;
   logic [4:0] inc5;
   logic [7:0] diff8;
   logic [1:0] sh;
   logic       c;
   logic       v;

   function automatic logic [6:0] hex_glyph(input logic [3:0] x);
      case (x)
         4'h0: hex_glyph = 7'b1111110;
         4'h1: hex_glyph = 7'b0110000;
         4'h2: hex_glyph = 7'b1101101;
         4'h3: hex_glyph = 7'b1111001;
         4'h4: hex_glyph = 7'b0110011;
         4'h5: hex_glyph = 7'b1011011;
         4'h6: hex_glyph = 7'b1011111;
         4'h7: hex_glyph = 7'b1110000;
         4'h8: hex_glyph = 7'b1111111;
         4'h9: hex_glyph = 7'b1111011;
         4'hA: hex_glyph = 7'b1110111;
         4'hB: hex_glyph = 7'b0011111;
         4'hC: hex_glyph = 7'b1001110;
         4'hD: hex_glyph = 7'b0111101;
         4'hE: hex_glyph = 7'b1001111;
         default: hex_glyph = 7'b1000111;
      endcase
   endfunction

   function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
      case (n)
         2'd0: rotl4 = x;
         2'd1: rotl4 = {x[2:0], x[3]};
         2'd2: rotl4 = {x[1:0], x[3:2]};
         default: rotl4 = {x[0], x[3:1]};
      endcase
   endfunction

   always_comb begin
      sum5       = {1'b0, a} + {1'b0, b};
      inc5       = {1'b0, a} + 5'd1;
      diff8      = {4'b0000, a} - {4'b0000, b};
      sh         = b[1:0];
      nxt_result = '0;
      c          = 1'b0;
      v          = 1'b0;
      case (f)
         4'd0: begin
            nxt_result = {3'b000, sum5};
            c = sum5[4];
            v = (a[3] == b[3]) && (sum5[3] != a[3]);
         end
         4'd1: begin
            nxt_result = diff8;
            c = (a < b);
            v = (a[3] != b[3]) && (diff8[3] != a[3]);
         end
`ifdef ALU_MUL_EN
         4'd2:  nxt_result = {4'b0000, a} * {4'b0000, b};
`else
         4'd2:  nxt_result = '0;
`endif
         4'd3:  nxt_result = {4'b0000, a & b};
         4'd4:  nxt_result = {4'b0000, a | b};
         4'd5:  nxt_result = {4'b0000, a ^ b};
         4'd6:  nxt_result = {4'b0000, ~(a & b)};
         4'd7:  nxt_result = {4'b0000, ~(a | b)};
         4'd8:  nxt_result = {4'b0000, ~(a ^ b)};
         4'd9:  nxt_result = {4'b0000, ~a};
         4'd10: nxt_result = {4'b0000, a} << sh;
         4'd11: begin
            nxt_result = {4'b0000, a >> sh};
            // last bit shifted out is a[sh-1]; no bit leaves on a zero shift
            c = (sh == 2'd0) ? 1'b0 : a[sh - 2'd1];
         end
         4'd12: nxt_result = {4'b0000, rotl4(a, sh)};
         // right rotate by n is left rotate by (4-n) mod 4
         4'd13: nxt_result = {4'b0000, rotl4(a, 2'd0 - sh)};
         4'd14: begin
            nxt_result = {3'b000, inc5};
            c = inc5[4];
         end
         default: begin
            if (a > b)       nxt_result = 8'h01;
            else if (a == b) nxt_result = 8'h00;
            else             nxt_result = 8'hFF;
         end
      endcase
      nxt_bank = {c, (nxt_result == 8'h00), nxt_result[7], v};

      // select toggles on the edge where the counter wraps back to zero
      nxt_sel = sel;
      if (&cnt) nxt_sel = (sel == DIG_LO) ? DIG_HI : DIG_LO;

      // du is built from the next result and next select so the registered
      // segment drive always matches the registered digit enables
      nxt_du = hex_glyph((nxt_sel == DIG_HI) ? nxt_result[7:4] : nxt_result[3:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         sel    <= DIG_LO;
         result <= '0;
         bank   <= '0;
         du     <= 7'b1111110;
         d0     <= 1'b1;
         d1     <= 1'b0;
      end else begin
         cnt    <= cnt + REFRESH_BITS'(1);
         sel    <= nxt_sel;
         result <= nxt_result;
         bank   <= nxt_bank;
         du     <= nxt_du;
         d0     <= (nxt_sel == DIG_LO);
         d1     <= (nxt_sel == DIG_HI);
      end
   end

   // result is held as architectural state; its nibbles reach the pins via du
   logic unused_result;
   assign unused_result = ^result;

endmodule

// File: tb/tb_alu_code_unit.sv
module tb_alu_code_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] f;
   logic [6:0] du;
   logic       d0;
   logic       d1;
   logic [3:0] bank;

   alu_code_unit #(.REFRESH_BITS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .f     (f),
      .du    (du),
      .d0    (d0),
      .d1    (d1),
      .bank  (bank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] f;
      logic [7:0] res;
      logic [3:0] bank;
   } vec_t;

   typedef struct {
      logic [3:0] bank;
      logic       d0;
      logic       d1;
      logic [6:0] du;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s [vec %0d]: got %h, expected %h", name, tag, act, req);
      end
   endtask

   // monitor: every cycle the DUT presents a new registered output word
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("bank", e.tag, {4'h0, bank}, {4'h0, e.bank});
            check("d0",   e.tag, {7'h0, d0},   {7'h0, e.d0});
            check("d1",   e.tag, {7'h0, d1},   {7'h0, e.d1});
            check("du",   e.tag, {1'b0, du},   {1'b0, e.du});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   vec_t vecs[$];
   int   edge_n;

   // With REFRESH_BITS=1 the select after edge n (counted from reset release)
   // is high for n mod 4 in {2,3}.
   task automatic run_vec(input int tag, input vec_t v);
      exp_t e;
      logic sel;
      a = v.a; b = v.b; f = v.f;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         edge_n++;
         sel    = ((edge_n / 2) % 2) == 1;
         e.bank = v.bank;
         e.d0   = !sel;
         e.d1   = sel;
         e.du   = sel ? glyph[v.res[7:4]] : glyph[v.res[3:0]];
         e.tag  = tag;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input int tag);
      check("rst_bank", tag, {4'h0, bank}, 8'h00);
      check("rst_d0",   tag, {7'h0, d0},   8'h01);
      check("rst_d1",   tag, {7'h0, d1},   8'h00);
      check("rst_du",   tag, {1'b0, du},   8'h7E);
   endtask

   initial begin
      //            a      b      f      res    bank {C,Z,N,V}
      vecs.push_back('{4'd1,  4'd1,  4'd0,  8'h02, 4'b0000});
      vecs.push_back('{4'd2,  4'd1,  4'd1,  8'h01, 4'b0000});
      vecs.push_back('{4'd1,  4'd2,  4'd1,  8'hFF, 4'b1010});
      vecs.push_back('{4'd15, 4'd0,  4'd5,  8'h0F, 4'b0000});
      vecs.push_back('{4'd7,  4'd1,  4'd0,  8'h08, 4'b0001});
      vecs.push_back('{4'd0,  4'd0,  4'd3,  8'h00, 4'b0100});
`ifdef ALU_MUL_EN
      vecs.push_back('{4'd15, 4'd15, 4'd2,  8'hE1, 4'b0010});
`else
      vecs.push_back('{4'd15, 4'd15, 4'd2,  8'h00, 4'b0100});
`endif
      vecs.push_back('{4'd8,  4'd8,  4'd0,  8'h10, 4'b1001});
      vecs.push_back('{4'd8,  4'd1,  4'd1,  8'h07, 4'b0001});
      vecs.push_back('{4'd9,  4'd2,  4'd10, 8'h24, 4'b0000});
      vecs.push_back('{4'd13, 4'd3,  4'd11, 8'h01, 4'b1000});
      vecs.push_back('{4'd4,  4'd3,  4'd11, 8'h00, 4'b1100});
      vecs.push_back('{4'd5,  4'd0,  4'd11, 8'h05, 4'b0000});
      vecs.push_back('{4'd9,  4'd1,  4'd12, 8'h03, 4'b0000});
      vecs.push_back('{4'd9,  4'd1,  4'd13, 8'h0C, 4'b0000});
      vecs.push_back('{4'd15, 4'd0,  4'd14, 8'h10, 4'b1000});
      vecs.push_back('{4'd5,  4'd9,  4'd15, 8'hFF, 4'b0010});
      vecs.push_back('{4'd9,  4'd9,  4'd15, 8'h00, 4'b0100});
      vecs.push_back('{4'd12, 4'd4,  4'd15, 8'h01, 4'b0000});
      vecs.push_back('{4'd5,  4'd3,  4'd6,  8'h0E, 4'b0000});
      vecs.push_back('{4'd0,  4'd0,  4'd7,  8'h0F, 4'b0000});
      vecs.push_back('{4'd10, 4'd5,  4'd8,  8'h00, 4'b0100});
      vecs.push_back('{4'd6,  4'd0,  4'd9,  8'h09, 4'b0000});
      vecs.push_back('{4'd12, 4'd10, 4'd4,  8'h0E, 4'b0000});

      rst_n = 1'b0; a = 4'd0; b = 4'd0; f = 4'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs(-1);
      rst_n  = 1'b1;
      edge_n = 0;

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // reset mid-refresh: outputs return to reset values, counter restarts
      #2 rst_n = 1'b0;
      #1 check_reset_outputs(-2);
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
      run_vec(100, vecs[0]);
      run_vec(101, vecs[2]);

      @(negedge clk);
      check("queue_drained", -3, 8'(q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
